count_stream_decoder: RTL and testbench
=======================================

Name: count_stream_decoder

Overview:
- Receive-side companion to the synchronous up/down counter.
- Samples a WIDTH-bit count stream, classifies each valid step as up, down, hold or illegal, and reports direction pulses.
- Acquires and holds lock on a well-formed stream, and keeps a signed net position.
- Sits downstream of a counter, or of any link carrying its value, as a checker and direction recovery block.

Parameters:
- WIDTH, 3, bit width of count_in; arithmetic is modulo 2^WIDTH.
- LOCK_CNT, 2, consecutive legal steps in ACQUIRE needed to enter LOCKED (range 1..15).
- ERR_LIMIT, 3, consecutive illegal steps in LOCKED that force a return to IDLE (range 1..15).
- POS_W, 8, width of the signed position output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count_in is a valid sample this cycle.
- count_in  input  WIDTH  sampled counter value.
- up_pulse  output  1  one-cycle pulse: last sample was a +1 step.
- down_pulse  output  1  one-cycle pulse: last sample was a -1 step.
- hold_pulse  output  1  one-cycle pulse: last sample equalled the previous sample.
- err_pulse  output  1  one-cycle pulse: last sample was an illegal step.
- reversal  output  1  one-cycle pulse: step direction is opposite to the last non-hold step.
- locked  output  1  level: FSM is in LOCKED.
- position  output  POS_W  signed net step count accumulated while LOCKED.

Behaviour:
- Reset (rst=1 at a clk edge, overrides en):
  - state=IDLE; prev, acq_cnt, err_cnt and last_dir cleared.
  - All pulses=0, locked=0, position=0.
- Sampling:
  - Acts only on edges with en=1.
  - en=0: no state change, all pulses 0.
- Step classification: delta = (count_in - prev) mod 2^WIDTH.
  - delta=1 is up; delta=2^WIDTH-1 is down; delta=0 is hold; any other value is an error.
  - Wrap is legal: 7->0 is up and 0->7 is down (WIDTH=3).
- Latency:
  - Outputs are registered. A sample taken at edge N drives its pulses/locked/position during cycle N+1.
  - At most one of up/down/hold/err is high per cycle.
  - prev <= count_in on every en sample, including illegal ones.
- FSM:
  - IDLE: first en sample loads prev only, with no pulse. Then state=ACQUIRE, acq_cnt=0.
  - ACQUIRE:
    - Legal step (up/down/hold): pulse, acq_cnt+1. When acq_cnt reaches LOCK_CNT, go to LOCKED; locked rises in the same cycle as that step's pulse.
    - Error: err_pulse, acq_cnt=0, stay in ACQUIRE.
    - Position is frozen.
  - LOCKED:
    - up: position+1. down: position-1.
    - Position saturates at +(2^(POS_W-1)-1) and -2^(POS_W-1); no wrap.
    - Legal step clears err_cnt.
    - Error: err_pulse, err_cnt+1. When err_cnt reaches ERR_LIMIT, go to IDLE; locked falls with that err_pulse. Position holds its value until rst.
- Reversal:
  - last_dir is updated on up/down only; hold leaves it unchanged.
  - reversal pulses with up_pulse/down_pulse when the direction differs from last_dir and last_dir is valid.
  - last_dir is invalidated on entry to IDLE.
- Reset mid-stream: the next en sample after rst is treated as the first sample, with no pulse.

Decomposition:
- Shared package count_pkg:
  - enum step_t {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_ERR}.
  - enum dec_state_t {DEC_IDLE, DEC_ACQUIRE, DEC_LOCKED}.
- One natural sub-module: count_step_classifier, a combinational block that takes prev and count_in and returns step_t.
- FSM, counters and position stay in the top module.

Test Plan:
- rst=1 for 2 cycles with en=1 and count_in=5 -> all outputs 0, position=0, no pulse on the first post-reset sample.
- en=1, count_in 0,1,2,3,4 -> up_pulse on samples 2..5, locked=1 from the cycle after sample 3, position=2 after sample 5.
- While locked, count_in 6,7,0 then 0,7,6 -> up pulses across the 7->0 wrap, then hold, then down pulses. reversal pulses on 0->7 only; position returns to its pre-sequence value +2-2.
- While locked, count_in 2,5,1,6 (illegal jumps) -> err_pulse x3. locked drops with the third error, and the next sample produces no pulse (IDLE reload).
- ACQUIRE with count_in 1,2,5,6,7 -> err on 5, acq_cnt restarts, locked=1 only after 6->7.
- Drive monotonic up for 200 steps with POS_W=8 -> position saturates at 127. Assert rst mid-burst -> next cycle all outputs 0.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types for the count stream decoder: step classification and
// decoder state encodings.
package count_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_UP,
      STEP_DOWN,
      STEP_ERR
   } step_t;

   typedef enum logic [1:0] {
      DEC_IDLE,
      DEC_ACQUIRE,
      DEC_LOCKED
   } dec_state_t;

   function automatic logic step_is_legal(input step_t s);
      return s != STEP_ERR;
   endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Combinational classifier: compares a sample against the previous one
// modulo 2^WIDTH and reports hold, +1, -1 or illegal.
import count_pkg::*;

module count_step_classifier #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] prev,
   input  logic [WIDTH-1:0] count_in,
   output step_t            step
);

   logic [WIDTH-1:0] delta;

   // Wrap is legal because the subtraction is naturally modulo 2^WIDTH.
   always_comb begin
      delta = count_in - prev;
      step  = STEP_ERR;
      if (delta == '0)
         step = STEP_HOLD;
      else if (delta == WIDTH'(1))
         step = STEP_UP;
      else if (delta == '1)
         step = STEP_DOWN;
   end

endmodule

// File: rtl/count_stream_decoder.sv
// Receive-side checker for an up/down counter stream: classifies steps,
// acquires/holds lock, tracks reversals and a saturating net position.
import count_pkg::*;

module count_stream_decoder #(
   parameter int WIDTH     = 3,
   parameter int LOCK_CNT  = 2,
   parameter int ERR_LIMIT = 3,
   parameter int POS_W     = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [WIDTH-1:0]        count_in,
   output logic                    up_pulse,
   output logic                    down_pulse,
   output logic                    hold_pulse,
   output logic                    err_pulse,
   output logic                    reversal,
   output logic                    locked,
   output logic signed [POS_W-1:0] position
);

   localparam logic [CNT_W-1:0]        LOCK_C  = CNT_W'(LOCK_CNT);
   localparam logic [CNT_W-1:0]        ERR_C   = CNT_W'(ERR_LIMIT);
   localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
   localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

   function automatic logic signed [POS_W-1:0] sat_step(
      input logic signed [POS_W-1:0] p,
      input logic                    inc,
      input logic                    dec
   );
      logic signed [POS_W-1:0] r;
      r = p;
      if (inc && (p != POS_MAX))
         r = p + POS_ONE;
      else if (dec && (p != POS_MIN))
         r = p - POS_ONE;
      return r;
   endfunction

   dec_state_t              state, state_nxt;
   logic [WIDTH-1:0]        prev, prev_nxt;
   logic [CNT_W-1:0]        acq_cnt, acq_cnt_nxt;
   logic [CNT_W-1:0]        err_cnt, err_cnt_nxt;
   logic                    dir_vld, dir_vld_nxt;
   logic                    dir_up, dir_up_nxt;
   logic signed [POS_W-1:0] pos_nxt;
   logic                    up_nxt, down_nxt, hold_nxt, err_nxt, rev_nxt;
   step_t                   step;
   logic                    is_up, is_down, legal;

   count_step_classifier #(
      .WIDTH (WIDTH)
   ) u_classifier (
      .prev     (prev),
      .count_in (count_in),
      .step     (step)
   );

   assign is_up   = (step == STEP_UP);
   assign is_down = (step == STEP_DOWN);
   assign legal   = step_is_legal(step);
   assign locked  = (state == DEC_LOCKED);

   always_comb begin
      state_nxt   = state;
      prev_nxt    = prev;
      acq_cnt_nxt = acq_cnt;
      err_cnt_nxt = err_cnt;
      dir_vld_nxt = dir_vld;
      dir_up_nxt  = dir_up;
      pos_nxt     = position;
      up_nxt      = 1'b0;
      down_nxt    = 1'b0;
      hold_nxt    = 1'b0;
      err_nxt     = 1'b0;
      rev_nxt     = 1'b0;

      if (en) begin
         prev_nxt = count_in;
         if (state == DEC_IDLE) begin
            // First sample only seeds prev; there is nothing to compare against.
            state_nxt   = DEC_ACQUIRE;
            acq_cnt_nxt = '0;
            err_cnt_nxt = '0;
         end else begin
            up_nxt   = is_up;
            down_nxt = is_down;
            hold_nxt = (step == STEP_HOLD);
            err_nxt  = !legal;

            if (is_up || is_down) begin
               rev_nxt     = dir_vld && (dir_up != is_up);
               dir_vld_nxt = 1'b1;
               dir_up_nxt  = is_up;
            end

            case (state)
               DEC_ACQUIRE: begin
                  if (legal) begin
                     if ((acq_cnt + CNT_ONE) == LOCK_C) begin
                        state_nxt   = DEC_LOCKED;
                        acq_cnt_nxt = '0;
                        err_cnt_nxt = '0;
                     end else begin
                        acq_cnt_nxt = acq_cnt + CNT_ONE;
                     end
                  end else begin
                     acq_cnt_nxt = '0;
                  end
               end
               DEC_LOCKED: begin
                  if (legal) begin
                     err_cnt_nxt = '0;
                     pos_nxt     = sat_step(position, is_up, is_down);
                  end else if ((err_cnt + CNT_ONE) == ERR_C) begin
                     state_nxt   = DEC_IDLE;
                     err_cnt_nxt = '0;
                     dir_vld_nxt = 1'b0;
                  end else begin
                     err_cnt_nxt = err_cnt + CNT_ONE;
                  end
               end
               default: state_nxt = DEC_IDLE;
            endcase
         end
      end
   end

   // Registered outputs: a sample at edge N is reported during cycle N+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= DEC_IDLE;
         prev       <= '0;
         acq_cnt    <= '0;
         err_cnt    <= '0;
         dir_vld    <= 1'b0;
         dir_up     <= 1'b0;
         position   <= '0;
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         hold_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         reversal   <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev       <= prev_nxt;
         acq_cnt    <= acq_cnt_nxt;
         err_cnt    <= err_cnt_nxt;
         dir_vld    <= dir_vld_nxt;
         dir_up     <= dir_up_nxt;
         position   <= pos_nxt;
         up_pulse   <= up_nxt;
         down_pulse <= down_nxt;
         hold_pulse <= hold_nxt;
         err_pulse  <= err_nxt;
         reversal   <= rev_nxt;
      end
   end

endmodule

// File: tb/tb_count_stream_decoder.sv
// Directed scoreboard bench for count_stream_decoder with an independent
// integer reference model of the decoder.
module tb_count_stream_decoder;

   localparam int WIDTH = 3;
   localparam int MODV  = 8;
   localparam int LOCKN = 2;
   localparam int ERRN  = 3;

   typedef struct packed {
      logic       up;
      logic       dn;
      logic       hold;
      logic       err;
      logic       rev;
      logic       lock;
      logic [7:0] pos;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [WIDTH-1:0]  count_in = '0;
   logic              up_pulse, down_pulse, hold_pulse, err_pulse, reversal, locked;
   logic signed [7:0] position;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_miss = 0;

   // Reference model state
   int m_state = 0;
   int m_prev = 0;
   int m_acq = 0;
   int m_err = 0;
   int m_pos = 0;
   bit m_dvld = 0;
   bit m_dup = 0;

   count_stream_decoder #(
      .WIDTH(WIDTH), .LOCK_CNT(LOCKN), .ERR_LIMIT(ERRN), .POS_W(8)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .count_in(count_in),
      .up_pulse(up_pulse), .down_pulse(down_pulse), .hold_pulse(hold_pulse),
      .err_pulse(err_pulse), .reversal(reversal), .locked(locked),
      .position(position)
   );

   always #5 clk = ~clk;

   task automatic apply(input logic r, input logic e, input int c, input string tag);
      exp_t x;
      exp_t got;
      int   d;
      rst      = r;
      en       = e;
      count_in = WIDTH'(c);
      x = '0;
      if (r) begin
         m_state = 0; m_prev = 0; m_acq = 0; m_err = 0; m_pos = 0;
         m_dvld = 0; m_dup = 0;
      end else if (e) begin
         if (m_state == 0) begin
            m_state = 1;
            m_acq = 0;
            m_err = 0;
         end else begin
            d = ((c % MODV) - m_prev + MODV) % MODV;
            x.hold = (d == 0);
            x.up   = (d == 1);
            x.dn   = (d == MODV - 1);
            x.err  = !(x.hold || x.up || x.dn);
            if (x.up || x.dn) begin
               x.rev  = m_dvld && (m_dup != x.up);
               m_dvld = 1;
               m_dup  = x.up;
            end
            if (m_state == 1) begin
               if (x.err) m_acq = 0;
               else begin
                  m_acq++;
                  if (m_acq == LOCKN) begin
                     m_state = 2; m_acq = 0; m_err = 0;
                  end
               end
            end else begin
               if (x.err) begin
                  m_err++;
                  if (m_err == ERRN) begin
                     m_state = 0; m_err = 0; m_dvld = 0;
                  end
               end else begin
                  m_err = 0;
                  if (x.up && m_pos < 127) m_pos++;
                  if (x.dn && m_pos > -128) m_pos--;
               end
            end
         end
         m_prev = c % MODV;
      end
      x.lock = (m_state == 2);
      x.pos  = 8'(m_pos);
      sb.push_back(x);

      @(posedge clk);
      #1;
      x   = sb.pop_front();
      got = {up_pulse, down_pulse, hold_pulse, err_pulse, reversal, locked, position};
      n_vec++;
      assert (got === x) else begin
         n_miss++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, x);
      end
   endtask

   initial begin
      // Reset overrides a valid sample
      apply(1, 1, 5, "reset0");
      apply(1, 1, 5, "reset1");

      // Ramp: first sample silent, lock after second legal step
      apply(0, 1, 0, "first_sample");
      apply(0, 1, 1, "ramp_up1");
      apply(0, 1, 2, "ramp_lock");
      apply(0, 1, 3, "ramp_pos1");
      apply(0, 1, 4, "ramp_pos2");
      apply(0, 0, 6, "en_low");

      // Wrap up through 7->0, hold, then reverse down
      apply(0, 1, 5, "pre_wrap");
      apply(0, 1, 6, "wrap_up6");
      apply(0, 1, 7, "wrap_up7");
      apply(0, 1, 0, "wrap_up0");
      apply(0, 1, 0, "hold0");
      apply(0, 1, 7, "wrap_down_rev");
      apply(0, 1, 6, "down6");

      // Illegal jumps drop lock on the third error; next sample reloads
      apply(0, 1, 2, "err1");
      apply(0, 0, 3, "err_en_low");
      apply(0, 1, 5, "err2");
      apply(0, 1, 1, "err3_unlock");
      apply(0, 1, 6, "idle_reload");

      // Acquisition restarts after an error
      apply(0, 1, 1, "acq_err_a");
      apply(0, 1, 2, "acq_up");
      apply(0, 1, 5, "acq_err_b");
      apply(0, 1, 6, "acq_up_again");
      apply(0, 1, 7, "acq_lock");

      // Long bursts saturate position at both limits
      for (int i = 0; i < 200; i++) apply(0, 1, i % MODV, "sat_up");
      for (int i = 0; i < 300; i++) apply(0, 1, ((6 - i) % MODV + MODV) % MODV, "sat_down");
      for (int i = 0; i < 4; i++) apply(0, 1, (i + 4) % MODV, "after_sat");

      // Reset mid-burst, then the next sample is treated as the first
      apply(1, 1, 1, "mid_reset");
      apply(0, 1, 3, "post_reset_first");
      apply(0, 1, 4, "post_reset_up");
      apply(0, 1, 3, "post_reset_down");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
